// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, op encodings and bit positions shared
// by the M-mode CSR unit and its counters.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic {
        MTVEC_DIRECT   = 1'b0,
        MTVEC_VECTORED = 1'b1
    } mtvec_mode_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam int unsigned IRQ_MSI = 3;
    localparam int unsigned IRQ_MTI = 7;
    localparam int unsigned IRQ_MEI = 11;

    function automatic int unsigned cause_msb(input int unsigned xlen);
        return xlen - 1;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit event counter with per-half CSR writes;
// any write replaces its half and suppresses that cycle's increment.
module csr_counter64
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            wr_lo_i,
    input  logic            wr_hi_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [63:0]     value_o
);

    logic [63:0] value_q;
    logic [63:0] value_d;

    if (XLEN == 32) begin : g_split
        always_comb begin
            value_d = value_q + 64'(inc_i);
            if (wr_lo_i || wr_hi_i) begin
                value_d = value_q;
            end
            if (wr_lo_i) begin
                value_d[31:0] = wdata_i;
            end
            if (wr_hi_i) begin
                value_d[63:32] = wdata_i;
            end
        end
    end else begin : g_full
        logic unused_hi;
        assign unused_hi = wr_hi_i;

        always_comb begin
            value_d = value_q + 64'(inc_i);
            if (wr_lo_i) begin
                value_d = 64'(wdata_i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/csr_unit.sv
// csr_unit: M-mode CSR file with CSRRW/RS/RC, trap entry, mret,
// interrupt gating and mcycle/minstret counters.
module csr_unit
    import csr_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET  = XLEN'(32'h8000_0000),
    parameter logic [XLEN-1:0] MHARTID      = '0,
    parameter bit              HAS_COUNTERS = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [1:0]      csr_op_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            illegal_o,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_val_i,
    input  logic            mret_i,
    input  logic            retire_i,
    input  logic            irq_soft_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    output logic            irq_pending_o,
    output logic [XLEN-1:0] trap_vector_o,
    output logic [XLEN-1:0] mepc_o
);

    localparam int unsigned CMSB = cause_msb(XLEN);
    localparam logic [XLEN-1:0] IRQ_MASK =
        XLEN'((32'd1 << IRQ_MSI) | (32'd1 << IRQ_MTI) | (32'd1 << IRQ_MEI));
    localparam logic [1:0] MXL = (XLEN == 64) ? 2'd2 : 2'd1;
    localparam logic [XLEN-1:0] MISA =
        {MXL, {(XLEN-28){1'b0}}, 26'h000_1100};

    logic            sts_mie_q, sts_mie_d;
    logic            sts_mpie_q, sts_mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mie_q, mie_d;

    logic [63:0]     mcycle, minstret;
    logic [XLEN-1:0] mstatus, mip, rdata, wval, tvec_base;
    logic            impl, ro, illegal, csr_we;
    logic            cyc_wr_lo, cyc_wr_hi, ret_wr_lo, ret_wr_hi;
    csr_op_e         op;

    assign op = csr_op_e'(csr_op_i);

    always_comb begin
        mstatus                                = '0;
        mstatus[MSTATUS_MIE]                   = sts_mie_q;
        mstatus[MSTATUS_MPIE]                  = sts_mpie_q;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_comb begin
        mip          = '0;
        mip[IRQ_MSI] = irq_soft_i;
        mip[IRQ_MTI] = irq_timer_i;
        mip[IRQ_MEI] = irq_ext_i;
    end

    always_comb begin
        rdata = '0;
        impl  = 1'b1;
        ro    = 1'b0;
        case (csr_addr_i)
            CSR_MSTATUS:  rdata = mstatus;
            CSR_MISA: begin
                rdata = MISA;
                ro    = 1'b1;
            end
            CSR_MIE:      rdata = mie_q;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MTVAL:    rdata = mtval_q;
            CSR_MIP: begin
                rdata = mip;
                ro    = 1'b1;
            end
            CSR_MCYCLE:   rdata = mcycle[XLEN-1:0];
            CSR_MINSTRET: rdata = minstret[XLEN-1:0];
            CSR_MCYCLEH: begin
                if (XLEN == 32) rdata = XLEN'(mcycle[63:32]);
                else            impl  = 1'b0;
            end
            CSR_MINSTRETH: begin
                if (XLEN == 32) rdata = XLEN'(minstret[63:32]);
                else            impl  = 1'b0;
            end
            CSR_MHARTID: begin
                rdata = MHARTID;
                ro    = 1'b1;
            end
            default:      impl = 1'b0;
        endcase
    end

    assign illegal = (op != CSR_OP_NONE) &&
                     (!impl || (ro && (csr_wdata_i != '0)));

    always_comb begin
        unique case (op)
            CSR_OP_RS: wval = rdata | csr_wdata_i;
            CSR_OP_RC: wval = rdata & ~csr_wdata_i;
            default:   wval = csr_wdata_i;
        endcase
    end

    // Set/clear with a zero mask is a pure read and must not write.
    assign csr_we = (op != CSR_OP_NONE) && !illegal &&
                    !trap_i && !mret_i &&
                    ((op == CSR_OP_RW) || (csr_wdata_i != '0));

    assign cyc_wr_lo = csr_we && (csr_addr_i == CSR_MCYCLE);
    assign cyc_wr_hi = csr_we && (csr_addr_i == CSR_MCYCLEH);
    assign ret_wr_lo = csr_we && (csr_addr_i == CSR_MINSTRET);
    assign ret_wr_hi = csr_we && (csr_addr_i == CSR_MINSTRETH);

    always_comb begin
        sts_mie_d  = sts_mie_q;
        sts_mpie_d = sts_mpie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mscratch_d = mscratch_q;
        mie_d      = mie_q;
        if (trap_i) begin
            sts_mpie_d = sts_mie_q;
            sts_mie_d  = 1'b0;
            mepc_d     = {trap_pc_i[XLEN-1:2], 2'b00};
            mcause_d   = trap_cause_i;
            mtval_d    = trap_val_i;
        end else if (mret_i) begin
            sts_mie_d  = sts_mpie_q;
            sts_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    sts_mie_d  = wval[MSTATUS_MIE];
                    sts_mpie_d = wval[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_d      = wval & IRQ_MASK;
                CSR_MTVEC:    mtvec_d    = {wval[XLEN-1:2], 1'b0, wval[0]};
                CSR_MSCRATCH: mscratch_d = wval;
                CSR_MEPC:     mepc_d     = {wval[XLEN-1:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = wval;
                CSR_MTVAL:    mtval_d    = wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sts_mie_q  <= 1'b0;
            sts_mpie_q <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mscratch_q <= '0;
            mie_q      <= '0;
        end else begin
            sts_mie_q  <= sts_mie_d;
            sts_mpie_q <= sts_mpie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mscratch_q <= mscratch_d;
            mie_q      <= mie_d;
        end
    end

    if (HAS_COUNTERS) begin : g_cnt
        csr_counter64 #(.XLEN(XLEN)) u_mcycle (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .inc_i   (1'b1),
            .wr_lo_i (cyc_wr_lo),
            .wr_hi_i (cyc_wr_hi),
            .wdata_i (wval),
            .value_o (mcycle)
        );
        csr_counter64 #(.XLEN(XLEN)) u_minstret (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .inc_i   (retire_i),
            .wr_lo_i (ret_wr_lo),
            .wr_hi_i (ret_wr_hi),
            .wdata_i (wval),
            .value_o (minstret)
        );
    end else begin : g_nocnt
        logic unused_cnt;
        assign unused_cnt = ^{retire_i, cyc_wr_lo, cyc_wr_hi,
                              ret_wr_lo, ret_wr_hi};
        assign mcycle     = '0;
        assign minstret   = '0;
    end

    assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

    // Only interrupts are vectored; exceptions always go to the base.
    always_comb begin
        trap_vector_o = tvec_base;
        if ((mtvec_mode_e'(mtvec_q[0]) == MTVEC_VECTORED) &&
            trap_cause_i[CMSB]) begin
            trap_vector_o = tvec_base + {trap_cause_i[XLEN-3:0], 2'b00};
        end
    end

    assign csr_rdata_o   = rdata;
    assign illegal_o     = illegal;
    assign irq_pending_o = sts_mie_q & (|(mie_q & mip));
    assign mepc_o        = mepc_q;

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: scenario tasks with a read-data scoreboard for the
// M-mode CSR unit (XLEN=32).
module tb_csr_unit;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    typedef struct packed {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } step_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        illegal;
    logic        trap;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret;
    logic        retire;
    logic        irq_soft, irq_timer, irq_ext;
    logic        irq_pending;
    logic [31:0] trap_vector;
    logic [31:0] mepc;

    sb_t sb[$];
    int  vectors     = 0;
    int  miscompares = 0;

    always #10 clk = ~clk;

    csr_unit #(
        .XLEN         (32),
        .MTVEC_RESET  (32'h8000_0000),
        .MHARTID      (32'h0),
        .HAS_COUNTERS (1'b1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .csr_addr_i    (csr_addr),
        .csr_op_i      (csr_op),
        .csr_wdata_i   (csr_wdata),
        .csr_rdata_o   (csr_rdata),
        .illegal_o     (illegal),
        .trap_i        (trap),
        .trap_cause_i  (trap_cause),
        .trap_pc_i     (trap_pc),
        .trap_val_i    (trap_val),
        .mret_i        (mret),
        .retire_i      (retire),
        .irq_soft_i    (irq_soft),
        .irq_timer_i   (irq_timer),
        .irq_ext_i     (irq_ext),
        .irq_pending_o (irq_pending),
        .trap_vector_o (trap_vector),
        .mepc_o        (mepc)
    );

    task automatic apply(input string n, input step_t s);
        csr_op    = s.op;
        csr_addr  = s.addr;
        csr_wdata = s.wd;
        if (s.chk) sb.push_back('{n, s.exp});
    endtask

    task automatic idle();
        csr_op = OP_NONE; csr_addr = '0; csr_wdata = '0;
        trap = 1'b0; trap_cause = '0; trap_pc = '0; trap_val = '0;
        mret = 1'b0; retire = 1'b0;
    endtask

    task automatic test_reset();
        step_t st[8];
        sb_t   s;
        idle();
        irq_soft = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        st[0] = '{OP_RS, 12'h300, 32'h0, 1'b1, 32'h0000_1800};
        st[1] = '{OP_RS, 12'h305, 32'h0, 1'b1, 32'h8000_0000};
        st[2] = '{OP_RS, 12'h341, 32'h0, 1'b1, 32'h0};
        st[3] = '{OP_RS, 12'h342, 32'h0, 1'b1, 32'h0};
        st[4] = '{OP_RS, 12'h343, 32'h0, 1'b1, 32'h0};
        st[5] = '{OP_RS, 12'h340, 32'h0, 1'b1, 32'h0};
        st[6] = '{OP_RS, 12'h304, 32'h0, 1'b1, 32'h0};
        st[7] = '{OP_RS, 12'hB00, 32'h0, 1'b1, 32'h0};
        for (int i = 0; i < 8; i++) begin
            apply($sformatf("reset_rd%0d", i), st[i]);
            #1;
            s = sb.pop_front();
            vectors++;
            if (csr_rdata !== s.exp) begin
                miscompares++;
                $display("FAIL %s got=%h exp=%h", s.name, csr_rdata, s.exp);
            end
        end
        vectors++;
        if (trap_vector !== 32'h8000_0000 || mepc !== 32'h0 ||
            irq_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outs got=%h/%h/%b exp=80000000/0/0",
                     trap_vector, mepc, irq_pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply($sformatf("mcycle_run%0d", i),
                  '{OP_RS, 12'hB00, 32'h0, 1'b1, 32'(i)});
            #1;
            s = sb.pop_front();
            vectors++;
            if (csr_rdata !== s.exp) begin
                miscompares++;
                $display("FAIL %s got=%h exp=%h", s.name, csr_rdata, s.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_scratch();
        logic [1:0]  ops[4];
        logic [31:0] wds[4];
        logic [31:0] model;
        sb_t         s;
        ops = '{OP_RW, OP_RS, OP_RC, OP_RS};
        wds = '{32'hA5A5_0000, 32'h0000_00FF, 32'hA500_0000, 32'h0};
        model = 32'h0;
        for (int i = 0; i < 4; i++) begin
            apply($sformatf("scratch%0d", i),
                  '{ops[i], 12'h340, wds[i], 1'b1, model});
            unique case (ops[i])
                OP_RW:   model = wds[i];
                OP_RS:   model = model | wds[i];
                default: model = model & ~wds[i];
            endcase
            #1;
            s = sb.pop_front();
            vectors++;
            if (csr_rdata !== s.exp) begin
                miscompares++;
                $display("FAIL %s got=%h exp=%h", s.name, csr_rdata, s.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_trap();
        step_t st[7];
        sb_t   s;
        st[0] = '{OP_RS, 12'h300, 32'h8, 1'b1, 32'h0000_1800};
        st[1] = '{OP_RW, 12'h305, 32'h8000_0001, 1'b1, 32'h8000_0000};
        st[2] = '{OP_RS, 12'h300, 32'h0, 1'b1, 32'h0000_1808};
        st[3] = '{OP_RS, 12'h300, 32'h0, 1'b1, 32'h0000_1880};
        st[4] = '{OP_RS, 12'h342, 32'h0, 1'b1, 32'h8000_0007};
        st[5] = '{OP_RS, 12'h300, 32'h0, 1'b1, 32'h0000_1888};
        st[6] = '{OP_RS, 12'h343, 32'h0, 1'b1, 32'h0000_DEAD};
        trap_cause = 32'h8000_0007;
        trap_pc    = 32'h8000_0102;
        trap_val   = 32'h0000_DEAD;
        for (int i = 0; i < 7; i++) begin
            apply($sformatf("trap%0d", i), st[i]);
            trap = (i == 2);
            mret = (i == 4);
            #1;
            s = sb.pop_front();
            vectors++;
            if (csr_rdata !== s.exp) begin
                miscompares++;
                $display("FAIL %s got=%h exp=%h", s.name, csr_rdata, s.exp);
            end
            if (i == 2) begin
                vectors++;
                if (trap_vector !== 32'h8000_001C) begin
                    miscompares++;
                    $display("FAIL trap_vec got=%h exp=8000001c", trap_vector);
                end
            end
            if (i == 3) begin
                vectors++;
                if (mepc !== 32'h8000_0100) begin
                    miscompares++;
                    $display("FAIL trap_mepc got=%h exp=80000100", mepc);
                end
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_priority();
        step_t st[3];
        sb_t   s;
        st[0] = '{OP_RW, 12'h341, 32'h0000_1234, 1'b1, 32'h8000_0100};
        st[1] = '{OP_RS, 12'h300, 32'h0, 1'b1, 32'h0000_1880};
        st[2] = '{OP_RS, 12'h342, 32'h0, 1'b1, 32'h0000_0002};
        trap_cause = 32'h0000_0002;
        trap_pc    = 32'h0000_0207;
        trap_val   = 32'h0;
        for (int i = 0; i < 3; i++) begin
            apply($sformatf("prio%0d", i), st[i]);
            trap = (i == 0);
            mret = (i == 0);
            #1;
            s = sb.pop_front();
            vectors++;
            if (csr_rdata !== s.exp) begin
                miscompares++;
                $display("FAIL %s got=%h exp=%h", s.name, csr_rdata, s.exp);
            end
            if (i == 0) begin
                vectors++;
                if (trap_vector !== 32'h8000_0000 || illegal !== 1'b0) begin
                    miscompares++;
                    $display("FAIL prio_vec got=%h/%b exp=80000000/0",
                             trap_vector, illegal);
                end
            end
            if (i == 1) begin
                vectors++;
                if (mepc !== 32'h0000_0204) begin
                    miscompares++;
                    $display("FAIL prio_mepc got=%h exp=00000204", mepc);
                end
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_counters();
        step_t st[11];
        sb_t   s;
        st[0]  = '{OP_RW, 12'hB80, 32'h0000_0012, 1'b0, 32'h0};
        st[1]  = '{OP_RW, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'h0};
        st[2]  = '{OP_RS, 12'hB00, 32'h0, 1'b1, 32'hFFFF_FFFF};
        st[3]  = '{OP_RS, 12'hB00, 32'h0, 1'b1, 32'h0};
        st[4]  = '{OP_RS, 12'hB80, 32'h0, 1'b1, 32'h0000_0013};
        st[5]  = '{OP_RW, 12'hB02, 32'hFFFF_FFFF, 1'b0, 32'h0};
        st[6]  = '{OP_RW, 12'hB82, 32'h0000_0077, 1'b0, 32'h0};
        st[7]  = '{OP_RS, 12'hB02, 32'h0, 1'b1, 32'hFFFF_FFFF};
        st[8]  = '{OP_RS, 12'hB82, 32'h0, 1'b1, 32'h0000_0077};
        st[9]  = '{OP_RS, 12'hB02, 32'h0, 1'b1, 32'h0};
        st[10] = '{OP_RS, 12'hB82, 32'h0, 1'b1, 32'h0000_0078};
        for (int i = 0; i < 11; i++) begin
            apply($sformatf("cnt%0d", i), st[i]);
            retire = (i == 6) || (i == 8);
            #1;
            if (st[i].chk) begin
                s = sb.pop_front();
                vectors++;
                if (csr_rdata !== s.exp) begin
                    miscompares++;
                    $display("FAIL %s got=%h exp=%h",
                             s.name, csr_rdata, s.exp);
                end
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_illegal();
        step_t st[6];
        sb_t   s;
        st[0] = '{OP_RW,   12'hF14, 32'h5, 1'b1, 32'h0};
        st[1] = '{OP_RW,   12'h7C0, 32'h1, 1'b0, 32'h0};
        st[2] = '{OP_RS,   12'h340, 32'h0, 1'b1, 32'h00A5_00FF};
        st[3] = '{OP_RS,   12'hF14, 32'h0, 1'b1, 32'h0};
        st[4] = '{OP_RS,   12'h301, 32'h0, 1'b1, 32'h4000_1100};
        st[5] = '{OP_NONE, 12'h7C0, 32'h0, 1'b0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            apply($sformatf("ill%0d", i), st[i]);
            #1;
            if (st[i].chk) begin
                s = sb.pop_front();
                vectors++;
                if (csr_rdata !== s.exp) begin
                    miscompares++;
                    $display("FAIL %s got=%h exp=%h",
                             s.name, csr_rdata, s.exp);
                end
            end
            vectors++;
            if (illegal !== (i < 2)) begin
                miscompares++;
                $display("FAIL ill_flag%0d got=%b exp=%b", i, illegal, i < 2);
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_irq();
        step_t st[5];
        sb_t   s;
        st[0] = '{OP_RW, 12'h304, 32'h80, 1'b1, 32'h0};
        st[1] = '{OP_RS, 12'h304, 32'h0,  1'b1, 32'h80};
        st[2] = '{OP_RS, 12'h300, 32'h8,  1'b1, 32'h0000_1880};
        st[3] = '{OP_RS, 12'h344, 32'h0,  1'b1, 32'h80};
        st[4] = '{OP_RS, 12'h344, 32'h0,  1'b1, 32'h808};
        for (int i = 0; i < 5; i++) begin
            apply($sformatf("irq%0d", i), st[i]);
            irq_timer = (i >= 1) && (i <= 3);
            irq_soft  = (i == 4);
            irq_ext   = (i == 4);
            #1;
            s = sb.pop_front();
            vectors++;
            if (csr_rdata !== s.exp) begin
                miscompares++;
                $display("FAIL %s got=%h exp=%h", s.name, csr_rdata, s.exp);
            end
            vectors++;
            if (irq_pending !== (i == 3)) begin
                miscompares++;
                $display("FAIL irq_pend%0d got=%b exp=%b",
                         i, irq_pending, i == 3);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        step_t st[3];
        sb_t   s;
        apply("unused", '{OP_RW, 12'h340, 32'h1, 1'b0, 32'h0});
        trap       = 1'b1;
        trap_cause = 32'h8000_000B;
        trap_pc    = 32'h0000_0400;
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (mepc !== 32'h0 || irq_pending !== 1'b0 ||
            trap_vector !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL arst_outs got=%h/%b/%h exp=0/0/80000000",
                     mepc, irq_pending, trap_vector);
        end
        trap  = 1'b0;
        st[0] = '{OP_RS, 12'h340, 32'h0, 1'b1, 32'h0};
        st[1] = '{OP_RS, 12'h300, 32'h0, 1'b1, 32'h0000_1800};
        st[2] = '{OP_RS, 12'h304, 32'h0, 1'b1, 32'h0};
        for (int i = 0; i < 3; i++) begin
            apply($sformatf("arst%0d", i), st[i]);
            #1;
            s = sb.pop_front();
            vectors++;
            if (csr_rdata !== s.exp) begin
                miscompares++;
                $display("FAIL %s got=%h exp=%h", s.name, csr_rdata, s.exp);
            end
        end
        idle();
        irq_soft = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply("arst_mcycle", '{OP_RS, 12'hB00, 32'h0, 1'b1, 32'h1});
        #1;
        s = sb.pop_front();
        vectors++;
        if (csr_rdata !== s.exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", s.name, csr_rdata, s.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scratch();
        test_trap();
        test_priority();
        test_counters();
        test_illegal();
        test_irq();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised M-mode CSR file for the core; successor to the fixed four-register CSR block.
- Executes CSRRW/CSRRS/CSRRC internally, sequences trap entry and mret, and computes the trap vector in direct or vectored mode.
- Adds mie/mip interrupt gating, mscratch, mtval and 64-bit mcycle/minstret counters.
- Sits beside the execute stage; the PC mux consumes trap_vector_o and mepc_o.

Parameters:
- XLEN, 32, register width; legal values 32 or 64.
- MTVEC_RESET, 0x8000_0000, reset value of mtvec (mode bits 00).
- MHARTID, 0, constant returned by mhartid.
- HAS_COUNTERS, 1, when 0, counter CSRs read 0 and are legal no-ops.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous active-low reset.
- csr_addr_i  in  12  CSR address.
- csr_op_i  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear).
- csr_wdata_i  in  XLEN  rs1 value or zero-extended uimm.
- csr_rdata_o  out  XLEN  old CSR value, combinational.
- illegal_o  out  1  csr_op_i!=00 and (unimplemented address, or RW/RS/RC with nonzero wdata to a read-only address).
- trap_i  in  1  take exception or interrupt this cycle.
- trap_cause_i  in  XLEN  mcause value; MSB=1 means interrupt.
- trap_pc_i  in  XLEN  PC to save.
- trap_val_i  in  XLEN  mtval value.
- mret_i  in  1  execute mret.
- retire_i  in  1  one instruction retired.
- irq_soft_i, irq_timer_i, irq_ext_i  in  1 each  level interrupt lines.
- irq_pending_o  out  1  mstatus.MIE & |(mie & mip).
- trap_vector_o  out  XLEN  trap target PC, combinational.
- mepc_o  out  XLEN  current mepc.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - mstatus: MIE=0, MPIE=0, MPP=11.
  - mtvec=MTVEC_RESET.
  - mepc, mcause, mtval, mscratch, mie, mcycle, minstret = 0.
  - All outputs are derived from these values.
- Implemented CSRs:
  - mstatus 0x300: only bits 3 (MIE), 7 (MPIE) and 12:11 (MPP) exist; MPP is hardwired to 11; all other bits read 0.
  - misa 0x301: read-only, I + M, MXL from XLEN.
  - mie 0x304: bits 3, 7, 11 writable.
  - mtvec 0x305: bit 1 forced to 0.
  - mscratch 0x340.
  - mepc 0x341: bits 1:0 forced to 0.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: read-only; bits 3/7/11 = soft/timer/ext inputs, sampled combinationally.
  - mcycle 0xB00 and minstret 0xB02.
  - mcycleh 0xB80 and minstreth 0xB82: exist only when XLEN=32; illegal when XLEN=64.
  - mhartid 0xF14: read-only.
- Write value: RW uses wdata; RS uses old|wdata; RC uses old&~wdata. RS/RC with wdata=0 perform no write.
- Timing: writes commit at the posedge, and the new value is visible next cycle. A write is suppressed when illegal_o=1.
- Priority within a cycle is trap > mret > CSR write.
  - trap_i with mret_i: mret ignored.
  - trap_i or mret_i with a CSR op: the write is dropped, but csr_rdata_o is still driven.
- Trap entry:
  - MPIE<=MIE, MIE<=0.
  - mepc<=trap_pc_i&~3, mcause<=trap_cause_i, mtval<=trap_val_i.
- mret: MIE<=MPIE, MPIE<=1.
- trap_vector_o:
  - Direct mode (mtvec[0]=0), or an exception: {mtvec[XLEN-1:2],2'b00}.
  - Vectored mode with cause MSB=1: base + 4*cause[XLEN-2:0], wrapping modulo 2^XLEN.
- Counters:
  - mcycle increments every cycle out of reset; minstret increments when retire_i=1.
  - Both are 64-bit and wrap from 0xFFFF_FFFF_FFFF_FFFF to 0.
  - A CSR write to any half of a counter replaces that half and suppresses the increment for that cycle. The other half is unchanged, with no carry.
  - With XLEN=32, a carry out of the low half propagates into the high half in the same cycle.
- Reset asserted mid-operation: all state returns to reset values immediately; a trap in flight is lost.

Decomposition:
- Shared csr_pkg/defines header holds:
  - CSR address constants;
  - csr_op encodings;
  - mstatus/mie/mip bit positions;
  - mtvec mode encoding;
  - cause MSB position.
- One sub-module, csr_counter64 (clk_i, rst_i, inc_i, wr_lo_i, wr_hi_i, wdata_i, value_o), instantiated twice for mcycle and minstret.

Test Plan:
- Reset release, then read mstatus/mtvec/mcycle -> 0x1800, 0x8000_0000, then mcycle reads 1, 2, 3 on consecutive cycles.
- RW mscratch 0xA5A5_0000, RS 0x0000_00FF, then RC 0xA500_0000 -> reads 0xA5A5_0000, 0xA5A5_00FF, 0x00A5_00FF; each op's rdata returns the prior value.
- Set MIE, trap_i with cause 0x8000_0007 and pc 0x8000_0102, mtvec=0x8000_0001 -> trap_vector_o=0x8000_001C same cycle; next cycle mepc=0x8000_0100, MIE=0, MPIE=1. Then mret -> MIE=1, MPIE=1.
- trap_i, mret_i and RW mepc=0x1234 in one cycle -> only trap effects; mepc=trap_pc&~3.
- XLEN=32, write mcycle=0xFFFF_FFFF then let it run -> next cycle mcycle=0xFFFF_FFFF, following cycle mcycle=0 and mcycleh incremented by 1. Write minstreth with retire_i=1 -> written value held, no increment.
- Write mhartid or an unknown address 0x7C0 -> illegal_o=1 and no state change; irq_timer_i=1 with mie.MTIE=1 and MIE=1 -> irq_pending_o=1.
